// File: rtl/frame_buffer_arbiter.sv
// Round-robin arbiter sharing one single-command frame RAM between a pixel writer and a pixel reader.
// Optional read-behind-write tear guard enabled by defining FB_TEAR_GUARD_EN.
module frame_buffer_arbiter #(
  parameter int V = 8,
  parameter int S = 76800,
  parameter int A = 20
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         wr_valid_i,
  input  logic [V-1:0] wr_data_i,
  output logic         wr_ready_o,
  input  logic         rd_req_i,
  output logic         rd_ready_o,
  output logic         rd_valid_o,
  output logic [V-1:0] rd_data_o,
  output logic         wr_frame_done_o,
  output logic         rd_frame_done_o,
  output logic         ram_en_o,
  output logic         ram_we_o,
  output logic [V-1:0] ram_wdata_o,
  output logic [A-1:0] ram_waddr_o,
  output logic [A-1:0] ram_raddr_o,
  input  logic [V-1:0] ram_rdata_i
);

  // state | meaning
  // IDLE  | no grant since reset
  // WR    | last grant went to the writer
  // RD    | last grant went to the reader
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam logic [A-1:0] LAST_ADDR = A'(S - 1);

  state_t         r_state;
  logic [A-1:0]   r_wr_addr;
  logic [A-1:0]   r_rd_addr;
  logic           r_rd_pend;
  logic           r_rd_valid;
  logic           r_wr_done;
  logic           r_rd_done;
  logic           r_ram_en;
  logic           r_ram_we;
  logic [V-1:0]   r_ram_wdata;
  logic [A-1:0]   r_ram_waddr;
  logic [A-1:0]   r_ram_raddr;

  logic           w_block;
  logic           w_rd_allow;
  logic           w_wr_grant;
  logic           w_rd_grant;
  logic           w_wr_wrap;
  logic           w_rd_wrap;

`ifdef FB_TEAR_GUARD_EN
  // Set while the writer is a full frame ahead of the reader.
  logic r_frame_lag;
  assign w_rd_allow = !((r_rd_addr == r_wr_addr) && !r_frame_lag);
`else
  assign w_rd_allow = 1'b1;
`endif

  assign w_block    = rst_i | clear_i;
  assign w_wr_wrap  = (r_wr_addr == LAST_ADDR);
  assign w_rd_wrap  = (r_rd_addr == LAST_ADDR);
  assign w_wr_grant = !w_block && wr_valid_i &&
                      (!(rd_req_i && w_rd_allow) || (r_state != WR));
  assign w_rd_grant = !w_block && rd_req_i && w_rd_allow &&
                      (!wr_valid_i || (r_state == WR));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_ram_waddr <= '0;
      r_ram_raddr <= '0;
`ifdef FB_TEAR_GUARD_EN
      r_frame_lag <= 1'b0;
`endif
    end else begin
      // Read data leaves the RAM one edge after the address is presented.
      r_rd_pend  <= w_rd_grant;
      r_rd_valid <= r_rd_pend;
      r_ram_en   <= w_wr_grant | w_rd_grant;
      r_ram_we   <= w_wr_grant;
      r_wr_done  <= w_wr_grant && w_wr_wrap;
      r_rd_done  <= w_rd_grant && w_rd_wrap;
      if (clear_i) begin
        r_wr_addr <= '0;
        r_rd_addr <= '0;
`ifdef FB_TEAR_GUARD_EN
        r_frame_lag <= 1'b0;
`endif
      end else if (w_wr_grant) begin
        r_state     <= WR;
        r_ram_waddr <= r_wr_addr;
        r_ram_wdata <= wr_data_i;
        r_wr_addr   <= w_wr_wrap ? '0 : r_wr_addr + 1'b1;
`ifdef FB_TEAR_GUARD_EN
        if (w_wr_wrap) r_frame_lag <= !r_frame_lag;
`endif
      end else if (w_rd_grant) begin
        r_state     <= RD;
        r_ram_raddr <= r_rd_addr;
        r_rd_addr   <= w_rd_wrap ? '0 : r_rd_addr + 1'b1;
`ifdef FB_TEAR_GUARD_EN
        if (w_rd_wrap) r_frame_lag <= !r_frame_lag;
`endif
      end
    end
  end

  assign wr_ready_o      = w_wr_grant;
  assign rd_ready_o      = w_rd_grant;
  assign rd_valid_o      = r_rd_valid;
  assign rd_data_o       = ram_rdata_i;
  assign wr_frame_done_o = r_wr_done;
  assign rd_frame_done_o = r_rd_done;
  assign ram_en_o        = r_ram_en;
  assign ram_we_o        = r_ram_we;
  assign ram_wdata_o     = r_ram_wdata;
  assign ram_waddr_o     = r_ram_waddr;
  assign ram_raddr_o     = r_ram_raddr;

endmodule
